simple_alu_arbiter: RTL and testbench

Round-robin arbiter that shares one `simple_alu` instance between `NumReq` requesters. Each requester presents operands and an operation code through a valid-ready request port. The arbiter grants one requester at a time, drives the ALU operand ports, and routes the ALU result back to the granted requester through that requester's valid-ready response port. Exactly one transaction is in flight at a time, because the ALU holds a single result register.

---
 rtl/simple_alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_simple_alu_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_alu_arbiter.sv
// simple_alu_arbiter: round-robin sharing of one ALU between NumReq
// requesters, with exactly one transaction in flight at a time.
module simple_alu_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq*DataWidth-1:0] req_a_i,
    input  logic [NumReq*DataWidth-1:0] req_b_i,
    input  logic [NumReq*2-1:0]         req_op_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic [DataWidth-1:0]        rsp_result_o,
    output logic [NumReq-1:0]           rsp_valid_o,
    input  logic [NumReq-1:0]           rsp_ready_i,
    output logic [DataWidth-1:0]        alu_a_o,
    output logic [DataWidth-1:0]        alu_b_o,
    output logic [1:0]                  alu_config_o,
    output logic                        alu_valid_o,
    input  logic                        alu_ready_i,
    input  logic [DataWidth-1:0]        alu_result_i,
    input  logic                        alu_result_valid_i,
    output logic                        alu_result_ready_o,
    output logic                        busy_o,
    output logic [31:0]                 ops_done_o
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    state_e               state_q;
    logic [IdxW-1:0]      owner_q;
    logic [IdxW-1:0]      rr_ptr_q;
    logic [DataWidth-1:0] a_q;
    logic [DataWidth-1:0] b_q;
    logic [1:0]           op_q;
    logic [31:0]          ops_done_q;

    logic                 gnt_valid;
    logic [IdxW-1:0]      gnt_idx;
    logic [IdxW-1:0]      cand;
    logic [IdxW-1:0]      rr_ptr_d;
    logic [DataWidth-1:0] sel_a;
    logic [DataWidth-1:0] sel_b;
    logic [1:0]           sel_op;
    logic                 owner_ready;

    // First valid requester scanning upward from rr_ptr, wrapping at NumReq.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = IdxW'((int'(rr_ptr_q) + k) % NumReq);
            if (!gnt_valid && req_valid_i[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt_idx == IdxW'(i)) begin
                sel_a  = req_a_i[i*DataWidth +: DataWidth];
                sel_b  = req_b_i[i*DataWidth +: DataWidth];
                sel_op = req_op_i[i*2 +: 2];
            end
        end
    end

    assign rr_ptr_d = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    assign owner_ready = rsp_ready_i[owner_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            ops_done_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        op_q     <= sel_op;
                        owner_q  <= gnt_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (alu_ready_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (alu_result_valid_i && owner_ready) begin
                        ops_done_q <= ops_done_q + 32'd1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is masked while reset is held so every output reads zero.
    always_comb begin
        req_ready_o        = '0;
        rsp_valid_o        = '0;
        rsp_result_o       = '0;
        alu_result_ready_o = 1'b0;
        alu_a_o            = '0;
        alu_b_o            = '0;
        alu_config_o       = '0;
        alu_valid_o        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid && rst_ni) begin
                    req_ready_o[gnt_idx] = 1'b1;
                end
            end
            ISSUE: begin
                alu_a_o      = a_q;
                alu_b_o      = b_q;
                alu_config_o = op_q;
                alu_valid_o  = 1'b1;
            end
            WAIT: begin
                alu_a_o              = a_q;
                alu_b_o              = b_q;
                alu_config_o         = op_q;
                rsp_valid_o[owner_q] = alu_result_valid_i;
                rsp_result_o         = alu_result_i;
                alu_result_ready_o   = owner_ready;
            end
            default: ;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign ops_done_o = ops_done_q;

endmodule

// File: tb/tb_simple_alu_arbiter.sv
// Bench for simple_alu_arbiter: behavioural ALU, round-robin reference
// model and an in-order scoreboard checked by a free-running monitor.
module tb_simple_alu_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            clk;
    logic            rst_ni;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N*2-1:0]  req_op;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready_o;
    logic [DW-1:0]   rsp_result_o;
    logic [N-1:0]    rsp_valid_o;
    logic [N-1:0]    rsp_ready;
    logic [DW-1:0]   alu_a_o;
    logic [DW-1:0]   alu_b_o;
    logic [1:0]      alu_config_o;
    logic            alu_valid_o;
    logic            alu_ready;
    logic [DW-1:0]   alu_res;
    logic            alu_rv;
    logic            alu_result_ready_o;
    logic            busy_o;
    logic [31:0]     ops_done_o;
    logic            alu_en;

    simple_alu_arbiter #(.NumReq(N), .DataWidth(DW)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .req_a_i            (req_a),
        .req_b_i            (req_b),
        .req_op_i           (req_op),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready_o),
        .rsp_result_o       (rsp_result_o),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready),
        .alu_a_o            (alu_a_o),
        .alu_b_o            (alu_b_o),
        .alu_config_o       (alu_config_o),
        .alu_valid_o        (alu_valid_o),
        .alu_ready_i        (alu_ready),
        .alu_result_i       (alu_res),
        .alu_result_valid_i (alu_rv),
        .alu_result_ready_o (alu_result_ready_o),
        .busy_o             (busy_o),
        .ops_done_o         (ops_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return a & b;
        endcase
    endfunction

    // Behavioural ALU: combinational ready, registered result held until taken.
    assign alu_ready = !alu_rv && alu_en;
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_rv  <= 1'b0;
            alu_res <= '0;
        end else begin
            if (alu_rv && alu_result_ready_o) alu_rv <= 1'b0;
            if (alu_valid_o && alu_ready) begin
                alu_rv  <= 1'b1;
                alu_res <= alu_f(alu_config_o, alu_a_o, alu_b_o);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        int            idx;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    op;
        logic [DW-1:0] res;
    } txn_t;

    txn_t        sb[$];
    txn_t        t;
    int          eg;
    int          m_ptr;
    logic        m_busy;
    logic        m_wait;
    logic [31:0] m_done;
    int          acc_cnt[N];
    int          seen[N];

    initial begin
        m_ptr  = 0;
        m_busy = 1'b0;
        m_wait = 1'b0;
        m_done = '0;
        for (int i = 0; i < N; i++) begin
            acc_cnt[i] = 0;
            seen[i]    = 0;
        end
    end

    // Monitor: reference grant order and in-order response scoreboard.
    always @(negedge clk) begin
        if (!rst_ni) begin
            sb.delete();
            m_ptr  = 0;
            m_busy = 1'b0;
            m_wait = 1'b0;
            m_done = '0;
        end else begin
            chk("busy", {63'd0, busy_o}, {63'd0, m_busy});
            chk("ops_done", {32'd0, ops_done_o}, {32'd0, m_done});
            if (!m_busy) begin
                chk("idle_alu_valid", {63'd0, alu_valid_o}, 64'd0);
                chk("idle_rsp_valid", {60'd0, rsp_valid_o}, 64'd0);
                chk("idle_alu_a", alu_a_o, 64'd0);
                chk("idle_rsp_result", rsp_result_o, 64'd0);
                eg = rr_pick(req_valid, m_ptr);
                if (eg < 0) begin
                    chk("idle_ready", {60'd0, req_ready_o}, 64'd0);
                end else begin
                    chk("grant", {60'd0, req_ready_o}, 64'd1 << eg);
                    t.idx = eg;
                    t.a   = req_a[eg*DW +: DW];
                    t.b   = req_b[eg*DW +: DW];
                    t.op  = req_op[eg*2 +: 2];
                    t.res = alu_f(t.op, t.a, t.b);
                    sb.push_back(t);
                    m_ptr  = (eg + 1) % N;
                    m_busy = 1'b1;
                    acc_cnt[eg]++;
                end
            end else begin
                chk("masked_ready", {60'd0, req_ready_o}, 64'd0);
                if (!m_wait) begin
                    chk("issue_valid", {63'd0, alu_valid_o}, 64'd1);
                    chk("issue_rsp_valid", {60'd0, rsp_valid_o}, 64'd0);
                    chk("issue_res_ready", {63'd0, alu_result_ready_o}, 64'd0);
                    if (alu_ready) begin
                        chk("alu_a", alu_a_o, sb[0].a);
                        chk("alu_b", alu_b_o, sb[0].b);
                        chk("alu_op", {62'd0, alu_config_o}, {62'd0, sb[0].op});
                        m_wait = 1'b1;
                    end
                end else begin
                    chk("wait_alu_valid", {63'd0, alu_valid_o}, 64'd0);
                    chk("rsp_route", {60'd0, rsp_valid_o},
                        alu_rv ? (64'd1 << sb[0].idx) : 64'd0);
                    chk("res_ready", {63'd0, alu_result_ready_o},
                        {63'd0, rsp_ready[sb[0].idx]});
                    if (alu_rv) chk("rsp_result", rsp_result_o, sb[0].res);
                    if (alu_rv && rsp_ready[sb[0].idx]) begin
                        void'(sb.pop_front());
                        m_busy = 1'b0;
                        m_wait = 1'b0;
                        m_done = m_done + 32'd1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [1:0] op);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_op[i*2 +: 2]  = op;
    endtask

    task automatic rand_req(input int i);
        set_req(i, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                2'($urandom_range(3)));
    endtask

    task automatic wait_acc(input int i);
        for (int n = 0; n < 80; n++) begin
            tick();
            if (acc_cnt[i] != seen[i]) begin
                seen[i] = acc_cnt[i];
                return;
            end
        end
        chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input int i);
        req_valid[i] = 1'b1;
        wait_acc(i);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i);
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (rsp_valid_o[i]) return;
        end
        chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            if (!m_busy && sb.size() == 0) begin
                for (int i = 0; i < N; i++) seen[i] = acc_cnt[i];
                return;
            end
            tick();
        end
        chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_zero_outputs(input string n);
        chk({n, "_req_ready"}, {60'd0, req_ready_o}, 64'd0);
        chk({n, "_rsp_valid"}, {60'd0, rsp_valid_o}, 64'd0);
        chk({n, "_rsp_result"}, rsp_result_o, 64'd0);
        chk({n, "_alu_a"}, alu_a_o, 64'd0);
        chk({n, "_alu_b"}, alu_b_o, 64'd0);
        chk({n, "_alu_cfg"}, {62'd0, alu_config_o}, 64'd0);
        chk({n, "_alu_valid"}, {63'd0, alu_valid_o}, 64'd0);
        chk({n, "_res_ready"}, {63'd0, alu_result_ready_o}, 64'd0);
        chk({n, "_busy"}, {63'd0, busy_o}, 64'd0);
        chk({n, "_ops_done"}, {32'd0, ops_done_o}, 64'd0);
    endtask

    task automatic rand_step();
        for (int i = 0; i < N; i++) begin
            if (acc_cnt[i] != seen[i]) begin
                seen[i] = acc_cnt[i];
                rand_req(i);
                req_valid[i] = 1'($urandom_range(1));
            end else if (!req_valid[i]) begin
                if ($urandom_range(2) == 0) begin
                    rand_req(i);
                    req_valid[i] = 1'b1;
                end
            end else if ($urandom_range(19) == 0) begin
                req_valid[i] = 1'b0;
            end
            rsp_ready[i] = ($urandom_range(3) != 0);
        end
        alu_en = ($urandom_range(3) != 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni    = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        alu_en    = 1'b1;
        tick();
        chk_zero_outputs("reset");
        req_valid = '0;
        tick();
        rst_ni = 1'b1;
        tick();

        // Single request with nominal cycle timing.
        set_req(2, 64'd7, 64'd3, 2'd1);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_ready", {60'd0, req_ready_o}, 64'h4);
        tick();
        req_valid = '0;
        seen[2]   = acc_cnt[2];
        @(negedge clk);
        chk("t1_alu_valid", {63'd0, alu_valid_o}, 64'd1);
        tick();
        @(negedge clk);
        chk("t1_rsp_valid", {60'd0, rsp_valid_o}, 64'h4);
        chk("t1_result", rsp_result_o, 64'd4);
        tick();
        @(negedge clk);
        chk("t1_ops_done", {32'd0, ops_done_o}, 64'd1);
        tick();
        drain();

        // Fairness from a fresh pointer: grants 0,1,2,3,0 every 3 cycles.
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        for (int i = 0; i < N; i++) rand_req(i);
        req_valid = 4'hF;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("rr_c%0d", c), {60'd0, req_ready_o},
                (c % 3 == 0) ? (64'd1 << ((c / 3) % N)) : 64'd0);
        end
        tick();
        req_valid = '0;
        drain();

        // Randomized traffic with stalls and back-pressure.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rand_step();
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        alu_en    = 1'b1;
        drain();

        // Response back-pressure on requester 1 with requester 0 pending.
        set_req(1, 64'd6, 64'd5, 2'd2);
        rsp_ready = 4'b1101;
        send(1);
        set_req(0, 64'd11, 64'd12, 2'd0);
        req_valid[0] = 1'b1;
        wait_rsp(1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("bp_result", rsp_result_o, 64'd30);
            chk("bp_busy", {63'd0, busy_o}, 64'd1);
            chk("bp_no_grant", {60'd0, req_ready_o}, 64'd0);
            chk("bp_rsp_valid", {60'd0, rsp_valid_o}, 64'h2);
        end
        tick();
        rsp_ready = 4'hF;
        wait_acc(0);
        req_valid = '0;
        drain();

        // Pointer skip and wrap.
        rand_req(3);
        send(3);
        drain();
        rand_req(1);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("skip_grant", {60'd0, req_ready_o}, 64'h2);
        wait_acc(1);
        req_valid = '0;
        drain();
        rand_req(0);
        rand_req(2);
        req_valid = 4'b0101;
        @(negedge clk);
        chk("ptr_after_skip", {60'd0, req_ready_o}, 64'h4);
        wait_acc(2);
        req_valid = '0;
        drain();

        // Completion counter wrap.
        #1;
        force dut.ops_done_q = 32'hFFFF_FFFF;
        m_done = 32'hFFFF_FFFF;
        #1;
        release dut.ops_done_q;
        @(negedge clk);
        chk("pre_wrap", {32'd0, ops_done_o}, 64'hFFFF_FFFF);
        tick();
        rand_req(0);
        send(0);
        drain();
        @(negedge clk);
        chk("ops_wrap", {32'd0, ops_done_o}, 64'd0);
        tick();

        // Reset while waiting on a stalled response.
        rand_req(1);
        rsp_ready = 4'b1101;
        send(1);
        wait_rsp(1);
        tick();
        rst_ni    = 1'b0;
        req_valid = 4'hF;
        #1;
        chk_zero_outputs("midrst");
        tick();
        req_valid = '0;
        rsp_ready = 4'hF;
        tick();
        rst_ni = 1'b1;
        tick();
        for (int i = 0; i < N; i++) seen[i] = acc_cnt[i];
        set_req(2, 64'd100, 64'd58, 2'd0);
        send(2);
        drain();
        @(negedge clk);
        chk("post_rst_done", {32'd0, ops_done_o}, 64'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
